// File: rtl/an_decoder_seq_if.sv
// Decoder handshake bundle: codeword in (valid/ready), decoded result out (valid/ready).
// The decoder connects to the slave modport and the codeword source/result sink to the master modport.
interface an_dec_if #(
  parameter int A  = 19,
  parameter int CW = 9,
  parameter int DW = 4
);
  localparam int RW = $clog2(A);
  localparam int PW = $clog2(CW);

  logic          in_valid;
  logic          in_ready;
  logic [CW-1:0] in_ane;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_n;
  logic [RW-1:0] out_res;
  logic          out_err;
  logic [PW-1:0] out_pos;
  logic          out_neg;
  logic          out_uncorr;

  modport master (
    output in_valid, in_ane, out_ready,
    input  in_ready, out_valid, out_n, out_res, out_err, out_pos, out_neg, out_uncorr
  );

  modport slave (
    input  in_valid, in_ane, out_ready,
    output in_ready, out_valid, out_n, out_res, out_err, out_pos, out_neg, out_uncorr
  );
endinterface

// File: rtl/an_decoder_seq.sv
// Serial AN-code single-bit corrector: residue, syndrome fix, restoring divide by A; 2*CW+2 cycles
// from accept to out_valid. One word in flight; in_ready low until the result handshake, result held until out_ready.
module an_decoder_seq #(
  parameter int A    = 19,
  parameter int CW   = 9,
  parameter int DW   = 4,
  parameter int CNTW = 16
) (
  input  logic            clk,
  input  logic            rst,
  an_dec_if.slave         bus,
  input  logic            cnt_clr,
  output logic [CNTW-1:0] cnt_corr,
  output logic [CNTW-1:0] cnt_uncorr
);
  localparam int RW  = $clog2(A);
  localparam int PW  = $clog2(CW);
  localparam int CTW = $clog2(CW + 1);
  localparam logic [RW:0] A_W = (RW + 1)'(A);

  typedef enum logic [2:0] {IDLE, RES, FIX, DIV, OUT} state_t;

  // One restoring step: shift in b, subtract A when it fits.
  function automatic logic step_q(input logic [RW-1:0] r, input logic b);
    return {r, b} >= A_W;
  endfunction

  function automatic logic [RW-1:0] step_r(input logic [RW-1:0] r, input logic b);
    logic [RW:0] t;
    t = {r, b};
    if (t >= A_W) t = t - A_W;
    return t[RW-1:0];
  endfunction

  // Returns {hit, neg, pos}; ascending scan with first-hit latch keeps the lowest position.
  function automatic logic [PW+1:0] lookup(input logic [RW-1:0] r);
    logic [PW+1:0] f;
    int            p;
    f = '0;
    p = 1;
    for (int i = 0; i < CW; i++) begin
      if (!f[PW+1]) begin
        if (r == RW'(p))          f = {2'b10, PW'(i)};
        else if (r == RW'(A - p)) f = {2'b11, PW'(i)};
      end
      p = (p * 2) % A;
    end
    return f;
  endfunction

  state_t          state_q, state_d;
  logic [CTW-1:0]  cnt_q, cnt_d;
  logic [CW-1:0]   ane_q, ane_d;
  logic [CW-1:0]   word_q, word_d;
  logic [RW-1:0]   res_q, res_d;
  logic [RW-1:0]   rem_q, rem_d;
  logic [CW-1:0]   quo_q, quo_d;
  logic            err_q, err_d;
  logic [PW-1:0]   pos_q, pos_d;
  logic            neg_q, neg_d;
  logic            unc_q, unc_d;

  logic            in_ready_q, in_ready_d;
  logic            out_valid_q, out_valid_d;
  logic [DW-1:0]   out_n_q, out_n_d;
  logic [RW-1:0]   out_res_q, out_res_d;
  logic            out_err_q, out_err_d;
  logic [PW-1:0]   out_pos_q, out_pos_d;
  logic            out_neg_q, out_neg_d;
  logic            out_uncorr_q, out_uncorr_d;
  logic [CNTW-1:0] cnt_corr_q, cnt_corr_d;
  logic [CNTW-1:0] cnt_uncorr_q, cnt_uncorr_d;

  logic [PW+1:0]   lk;
  logic [CW:0]     bitv;
  logic [CW:0]     c;
  logic            n_big;
  logic            fin_unc;

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ane_d        = ane_q;
    word_d       = word_q;
    res_d        = res_q;
    rem_d        = rem_q;
    quo_d        = quo_q;
    err_d        = err_q;
    pos_d        = pos_q;
    neg_d        = neg_q;
    unc_d        = unc_q;
    out_valid_d  = out_valid_q;
    out_n_d      = out_n_q;
    out_res_d    = out_res_q;
    out_err_d    = out_err_q;
    out_pos_d    = out_pos_q;
    out_neg_d    = out_neg_q;
    out_uncorr_d = out_uncorr_q;
    cnt_corr_d   = cnt_corr_q;
    cnt_uncorr_d = cnt_uncorr_q;

    lk      = lookup(res_q);
    bitv    = (CW + 1)'(1) << lk[PW-1:0];
    c       = lk[PW] ? ({1'b0, ane_q} + bitv) : ({1'b0, ane_q} - bitv);
    n_big   = |quo_q[CW-1:DW];
    fin_unc = unc_q | n_big;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          ane_d   = bus.in_ane;
          word_d  = bus.in_ane;
          res_d   = '0;
          cnt_d   = '0;
          state_d = RES;
        end
      end
      RES: begin
        res_d  = step_r(res_q, word_q[CW-1]);
        word_d = word_q << 1;
        cnt_d  = cnt_q + 1'b1;
        if (cnt_q == CTW'(CW - 1)) state_d = FIX;
      end
      FIX: begin
        err_d = lk[PW+1];
        neg_d = lk[PW];
        pos_d = lk[PW-1:0];
        // C's top bit flags both borrow (C<0) and carry (C>=2^CW).
        if (res_q == '0) begin
          word_d = ane_q;
          unc_d  = 1'b0;
        end else if (!lk[PW+1]) begin
          word_d = ane_q;
          unc_d  = 1'b1;
        end else begin
          word_d = c[CW-1:0];
          unc_d  = c[CW];
        end
        rem_d   = '0;
        quo_d   = '0;
        cnt_d   = '0;
        state_d = DIV;
      end
      DIV: begin
        if (cnt_q != CTW'(CW)) begin
          rem_d  = step_r(rem_q, word_q[CW-1]);
          quo_d  = {quo_q[CW-2:0], step_q(rem_q, word_q[CW-1])};
          word_d = word_q << 1;
          cnt_d  = cnt_q + 1'b1;
        end else begin
          // Extra cycle after the last quotient bit registers the result.
          out_valid_d  = 1'b1;
          out_n_d      = fin_unc ? '0 : quo_q[DW-1:0];
          out_res_d    = res_q;
          out_err_d    = err_q;
          out_pos_d    = pos_q;
          out_neg_d    = neg_q;
          out_uncorr_d = fin_unc;
          state_d      = OUT;
        end
      end
      OUT: begin
        if (bus.out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
          if (out_err_q && cnt_corr_q != '1)      cnt_corr_d   = cnt_corr_q + 1'b1;
          if (out_uncorr_q && cnt_uncorr_q != '1) cnt_uncorr_d = cnt_uncorr_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (cnt_clr) begin
      cnt_corr_d   = '0;
      cnt_uncorr_d = '0;
    end
    in_ready_d = (state_d == IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ane_q        <= '0;
      word_q       <= '0;
      res_q        <= '0;
      rem_q        <= '0;
      quo_q        <= '0;
      err_q        <= 1'b0;
      pos_q        <= '0;
      neg_q        <= 1'b0;
      unc_q        <= 1'b0;
      in_ready_q   <= 1'b1;
      out_valid_q  <= 1'b0;
      out_n_q      <= '0;
      out_res_q    <= '0;
      out_err_q    <= 1'b0;
      out_pos_q    <= '0;
      out_neg_q    <= 1'b0;
      out_uncorr_q <= 1'b0;
      cnt_corr_q   <= '0;
      cnt_uncorr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ane_q        <= ane_d;
      word_q       <= word_d;
      res_q        <= res_d;
      rem_q        <= rem_d;
      quo_q        <= quo_d;
      err_q        <= err_d;
      pos_q        <= pos_d;
      neg_q        <= neg_d;
      unc_q        <= unc_d;
      in_ready_q   <= in_ready_d;
      out_valid_q  <= out_valid_d;
      out_n_q      <= out_n_d;
      out_res_q    <= out_res_d;
      out_err_q    <= out_err_d;
      out_pos_q    <= out_pos_d;
      out_neg_q    <= out_neg_d;
      out_uncorr_q <= out_uncorr_d;
      cnt_corr_q   <= cnt_corr_d;
      cnt_uncorr_q <= cnt_uncorr_d;
    end
  end

  // A correctly fixed word is a multiple of A, so the division must leave no remainder.
  always_ff @(posedge clk) begin
    if (!rst && state_q == DIV && cnt_q == CTW'(CW) && !unc_q)
      assert (rem_q == '0) else $error("nonzero division remainder %0d", rem_q);
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.out_valid  = out_valid_q;
  assign bus.out_n      = out_n_q;
  assign bus.out_res    = out_res_q;
  assign bus.out_err    = out_err_q;
  assign bus.out_pos    = out_pos_q;
  assign bus.out_neg    = out_neg_q;
  assign bus.out_uncorr = out_uncorr_q;
  assign cnt_corr       = cnt_corr_q;
  assign cnt_uncorr     = cnt_uncorr_q;
endmodule

// File: tb/tb_an_decoder_seq.sv
// Table-driven bench for an_decoder_seq (A=19, CW=9, DW=4) with a result scoreboard queue.
module tb_an_decoder_seq;
  logic        clk = 1'b0;
  logic        rst;
  logic        cnt_clr;
  logic [15:0] cnt_corr;
  logic [15:0] cnt_uncorr;

  always #5 clk = ~clk;

  an_dec_if #(.A(19), .CW(9), .DW(4)) bus ();

  an_decoder_seq #(.A(19), .CW(9), .DW(4), .CNTW(16)) dut (
    .clk        (clk),
    .rst        (rst),
    .bus        (bus),
    .cnt_clr    (cnt_clr),
    .cnt_corr   (cnt_corr),
    .cnt_uncorr (cnt_uncorr)
  );

  typedef struct {
    logic [8:0] ane;
    logic [3:0] n;
    logic [4:0] res;
    logic       err;
    logic [3:0] pos;
    logic       neg;
    logic       unc;
    int         hold;
  } vec_t;

  vec_t tbl[12];
  vec_t exp_q[$];
  int   n_cmp = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   t_acc = 0;
  int   m_corr = 0;
  int   m_unc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic check_out(input vec_t e, input string tag);
    chk($sformatf("%s out_n[%0d]", tag, e.ane),      int'(bus.out_n),      int'(e.n));
    chk($sformatf("%s out_res[%0d]", tag, e.ane),    int'(bus.out_res),    int'(e.res));
    chk($sformatf("%s out_err[%0d]", tag, e.ane),    int'(bus.out_err),    int'(e.err));
    chk($sformatf("%s out_pos[%0d]", tag, e.ane),    int'(bus.out_pos),    int'(e.pos));
    chk($sformatf("%s out_neg[%0d]", tag, e.ane),    int'(bus.out_neg),    int'(e.neg));
    chk($sformatf("%s out_uncorr[%0d]", tag, e.ane), int'(bus.out_uncorr), int'(e.unc));
  endtask

  task automatic send(input logic [8:0] ane);
    int k;
    k = 0;
    @(negedge clk);
    while (!bus.in_ready && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("in_ready_before_accept", int'(bus.in_ready), 1);
    bus.in_valid = 1'b1;
    bus.in_ane   = ane;
    @(posedge clk);
    #1;
    t_acc        = cyc;
    bus.in_valid = 1'b0;
  endtask

  task automatic recv(input logic clr, input int hold);
    vec_t e;
    int   k;
    logic seen;
    k    = 0;
    seen = 1'b0;
    while (k < 100 && !seen) begin
      @(posedge clk);
      #1;
      k++;
      if (k == 1) chk("busy_in_ready", int'(bus.in_ready), 0);
      seen = bus.out_valid;
    end
    chk("out_valid_seen", int'(seen), 1);
    if (!seen) return;
    chk("latency", cyc - t_acc, 20);
    chk("sb_depth", exp_q.size(), 1);
    if (exp_q.size() == 0) return;
    e = exp_q.pop_front();
    check_out(e, "result");
    for (int h = 0; h < hold; h++) begin
      @(posedge clk);
      #1;
      check_out(e, "hold");
      chk("hold in_ready", int'(bus.in_ready), 0);
      chk("hold out_valid", int'(bus.out_valid), 1);
    end
    bus.out_ready = 1'b1;
    cnt_clr       = clr;
    @(posedge clk);
    #1;
    bus.out_ready = 1'b0;
    cnt_clr       = 1'b0;
    if (clr) begin
      m_corr = 0;
      m_unc  = 0;
    end else begin
      m_corr += int'(e.err);
      m_unc  += int'(e.unc);
    end
    chk("out_valid_after_hs", int'(bus.out_valid), 0);
    chk("cnt_corr", int'(cnt_corr), m_corr);
    chk("cnt_uncorr", int'(cnt_uncorr), m_unc);
  endtask

  initial begin
    int seenv;
    //          ane   n   res err pos neg unc hold
    tbl[0]  = '{9'd209, 4'd11, 5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 0};
    tbl[1]  = '{9'd211, 4'd11, 5'd2,  1'b1, 4'd1, 1'b0, 1'b0, 0};
    tbl[2]  = '{9'd213, 4'd11, 5'd4,  1'b1, 4'd2, 1'b0, 1'b0, 0};
    tbl[3]  = '{9'd241, 4'd11, 5'd13, 1'b1, 4'd5, 1'b0, 1'b0, 0};
    tbl[4]  = '{9'd465, 4'd11, 5'd9,  1'b1, 4'd8, 1'b0, 1'b0, 0};
    tbl[5]  = '{9'd208, 4'd11, 5'd18, 1'b1, 4'd0, 1'b1, 1'b0, 0};
    tbl[6]  = '{9'd193, 4'd11, 5'd3,  1'b1, 4'd4, 1'b1, 1'b0, 0};
    tbl[7]  = '{9'd511, 4'd0,  5'd17, 1'b1, 4'd1, 1'b1, 1'b1, 0};
    tbl[8]  = '{9'd304, 4'd0,  5'd0,  1'b0, 4'd0, 1'b0, 1'b1, 5};
    tbl[9]  = '{9'd13,  4'd0,  5'd13, 1'b1, 4'd5, 1'b0, 1'b1, 0};
    tbl[10] = '{9'd0,   4'd0,  5'd0,  1'b0, 4'd0, 1'b0, 1'b0, 0};
    tbl[11] = '{9'd286, 4'd15, 5'd1,  1'b1, 4'd0, 1'b0, 1'b0, 2};

    rst           = 1'b1;
    cnt_clr       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_ane    = '0;
    bus.out_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst in_ready", int'(bus.in_ready), 1);
    chk("rst out_valid", int'(bus.out_valid), 0);
    chk("rst out_n", int'(bus.out_n), 0);
    chk("rst out_res", int'(bus.out_res), 0);
    chk("rst out_uncorr", int'(bus.out_uncorr), 0);
    chk("rst cnt_corr", int'(cnt_corr), 0);
    chk("rst cnt_uncorr", int'(cnt_uncorr), 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 12; i++) begin
      send(tbl[i].ane);
      exp_q.push_back(tbl[i]);
      recv(1'b0, tbl[i].hold);
    end

    // Reset while the word is in the divide phase: nothing may come out.
    send(9'd211);
    repeat (15) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    chk("midrst out_valid", int'(bus.out_valid), 0);
    chk("midrst in_ready", int'(bus.in_ready), 1);
    chk("midrst cnt_corr", int'(cnt_corr), 0);
    chk("midrst cnt_uncorr", int'(cnt_uncorr), 0);
    @(negedge clk);
    rst    = 1'b0;
    m_corr = 0;
    m_unc  = 0;
    seenv  = 0;
    repeat (30) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seenv++;
    end
    chk("midrst no result", seenv, 0);

    // Clear on the handshake edge beats the increment.
    send(9'd511);
    exp_q.push_back(tbl[7]);
    recv(1'b1, 0);
    send(9'd213);
    exp_q.push_back(tbl[2]);
    recv(1'b0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
